// File: rtl/mc_fetch_regs.sv
// mc_fetch_regs: PC / IR / MDR / ALUOut register stage for the multicycle MIPS datapath.
// Optional feature macro MC_INSTR_COUNT_EN adds the instr_count output (count of IRWrite edges).
module mc_fetch_regs #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PCSRC3_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [1:0]  PCSrc,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [31:0] mdr,
    output logic [31:0] alu_out
`ifdef MC_INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [1:0] {
        SRC_ALU    = 2'b00,
        SRC_ALUOUT = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_ALT    = 2'b11
    } pc_src_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q;
    logic [31:0] alu_out_q;
    logic        pc_load;
    logic [31:0] jump_target;
    pc_src_e     pc_src;

    assign pc_src      = pc_src_e'(PCSrc);
    assign pc_load     = PCWrite | (PCWriteCond & zero);
    // Jump target is built from the pre-edge pc and ir.
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            case (pc_src)
                SRC_ALU:    pc_d = alu_result;
                SRC_ALUOUT: pc_d = alu_out_q;
                SRC_JUMP:   pc_d = jump_target;
                SRC_ALT:    pc_d = (PCSRC3_HOLD != 0) ? pc_q : alu_result;
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (IRWrite) begin
            ir_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mem_rdata;
            alu_out_q <= alu_result;
        end
    end

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (IRWrite) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`endif

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign opcode   = ir_q[31:26];
    assign mdr      = mdr_q;
    assign alu_out  = alu_out_q;
    assign mem_addr = IorD ? alu_out_q : pc_q;

endmodule

// File: doc/mc_fetch_regs.md
Name: mc_fetch_regs

Overview:
- Datapath register stage paired with the multicycle MIPS controller.
- Holds PC, IR, MDR and ALUOut.
- Consumes the controller's PCWrite, PCWriteCond, IorD, IRWrite and PCSrc strobes; produces the memory address and the IR opcode field that feeds back into the controller.
- Sits between unified instruction/data memory, the ALU and the controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PCSRC3_HOLD, 1, when 1, PCSrc=2'b11 suppresses any PC load; when 0, it selects alu_result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PCWrite  in  1  unconditional PC load strobe from controller.
- PCWriteCond  in  1  conditional (beq) PC load strobe.
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  in  1  IR load strobe.
- PCSrc  in  2  next-PC select.
- zero  in  1  ALU zero flag, same cycle as PCWriteCond.
- alu_result  in  32  combinational ALU output.
- mem_rdata  in  32  memory read data, valid in the cycle it is addressed.
- pc  out  32  current PC register.
- mem_addr  out  32  memory address.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26], to controller.
- mdr  out  32  memory data register.
- alu_out  out  32  ALUOut register.

Behaviour:
- Single clock domain.
  - Reset is synchronous, active-high, and has priority over every write strobe in the same cycle.
  - Reset values: pc = RESET_PC, ir = 0 (opcode = 6'b000000), mdr = 0, alu_out = 0.
- mem_addr is combinational: IorD ? alu_out : pc. No added latency.
- alu_out latches alu_result on every non-reset edge; it is one cycle behind the ALU.
- mdr latches mem_rdata on every non-reset edge.
- ir latches mem_rdata only on an edge with IRWrite=1; otherwise it holds.
  - opcode is always ir[31:26] and is combinational from ir.
- pc_load = PCWrite | (PCWriteCond & zero).
- Next-PC select:
  - 00: alu_result (PC+4 in fetch).
  - 01: alu_out (branch target computed in decode).
  - 10: jump target {pc[31:28], ir[25:0], 2'b00}, using the current pc and ir, not next-state values.
  - 11: if PCSRC3_HOLD=1, no load occurs even when pc_load=1; if 0, behaves as 00.
- Simultaneous events on one edge:
  - Fetch cycle (IRWrite=1, PCWrite=1, IorD=0): ir takes the word read at the old pc; pc takes alu_result. Both updates occur on the same edge.
  - PCWrite=1 with PCWriteCond=1: the load happens regardless of zero.
  - PCWriteCond=1, zero=0, PCWrite=0: pc holds.
- PC wraps naturally at 32 bits: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no alignment check.
- Reset asserted mid-instruction aborts it: the next edge applies reset values regardless of strobes.
  - Controller state is reset separately; this block does not track controller state.
- X on unused strobes while rst=1 must not propagate to any register.

Optional Feature:
- Macro: MC_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count (32 bits), reset to 0.
  - Increments by 1 on every non-reset edge with IRWrite=1.
  - Wraps from 32'hFFFF_FFFF to 0.
  - A cycle with rst=1 and IRWrite=1 leaves the count at 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst one cycle with PCWrite=1, alu_result=32'h40 -> pc=32'h0, ir=0, opcode=000000, mdr=0, alu_out=0.
- Fetch: pc=0, IorD=0, mem_rdata=32'h8C22_0004, IRWrite=1, PCWrite=1, PCSrc=00, alu_result=4 -> after edge ir=32'h8C22_0004, opcode=100011, pc=4; mem_addr=0 before the edge.
- Branch taken/not taken: alu_out=32'h20, PCSrc=01, PCWriteCond=1, PCWrite=0:
  - zero=1 -> pc=32'h20.
  - Repeat with zero=0 -> pc unchanged.
- Jump: pc=32'h1000_0010, ir=32'h0800_0100, PCSrc=10, PCWrite=1 -> pc=32'h1000_0400.
- Memory access and PCSrc=11 hold:
  - IorD=1 with alu_out=32'h44 -> mem_addr=32'h44; mdr equals mem_rdata after the next edge.
  - PCSrc=11, PCWrite=1 (PCSRC3_HOLD=1) -> pc unchanged.
- Counter (MC_INSTR_COUNT_EN): 5 IRWrite pulses -> instr_count=5; rst -> 0; preload to 32'hFFFF_FFFF via 2^32-1 pulses (or force) and pulse again -> 0.
